// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: eight-step instruction sequencer issuing fetch/execute strobes for a small accumulator CPU
module cpu_seq_ctrl #(
  parameter int OP_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output logic            load_ir,
  output logic            rd,
  output logic            wr,
  output logic            inc_pc,
  output logic            load_pc,
  output logic            load_acc,
  output logic            datactl_ena,
  output logic            halt,
  output logic            instr_done,
  output logic [2:0]      state
);
  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} step_t;
  localparam logic [OP_W-1:0] HLT = OP_W'(0);
  localparam logic [OP_W-1:0] SKZ = OP_W'(1);
  localparam logic [OP_W-1:0] ADD = OP_W'(2);
  localparam logic [OP_W-1:0] AND = OP_W'(3);
  localparam logic [OP_W-1:0] XOR = OP_W'(4);
  localparam logic [OP_W-1:0] LDA = OP_W'(5);
  localparam logic [OP_W-1:0] STO = OP_W'(6);
  localparam logic [OP_W-1:0] JMP = OP_W'(7);
  step_t st, st_nx;
  logic  halt_nx, run, alu, sto, jmp, skz_z, ex;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st   <= S0;
      halt <= 1'b0;
    end else begin
      st   <= st_nx;
      halt <= halt_nx;
    end
  end
  // Strobes are masked by ena/halt/rst_n so an abort or reset silences them in the same cycle.
  always_comb begin
    run         = rst_n && ena && !halt;
    alu         = opcode == ADD || opcode == AND || opcode == XOR || opcode == LDA;
    sto         = opcode == STO;
    jmp         = opcode == JMP;
    skz_z       = opcode == SKZ && zero;
    ex          = st == S4 || st == S5;
    halt_nx     = halt || (ena && st == S2 && opcode == HLT);
    st_nx       = halt ? st : !ena ? S0 : (st == S2 && opcode == HLT) ? S2 : step_t'(st + 3'd1);
    load_ir     = run && (st == S0 || st == S1);
    rd          = run && (st == S0 || st == S1 || (alu && (st == S3 || st == S4)));
    wr          = run && sto && st == S4;
    inc_pc      = run && (st == S0 || st == S1 || (skz_z && ex));
    load_pc     = run && jmp && ex;
    load_acc    = run && alu && st == S4;
    datactl_ena = run && sto && (st == S3 || ex);
    instr_done  = run && st == S7;
    state       = (ena || halt) ? st : S0;
  end
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: directed stimulus with a step-table reference model checked every cycle
module tb_cpu_seq_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1, zero = 1'b0;
  logic [2:0] opcode = 3'd5;
  logic       load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt, instr_done;
  logic [2:0] state;
  int         n_cmp = 0, n_bad = 0;
  int         m_step = 0;
  logic       m_halt = 1'b0;
  logic [7:0] vec;

  cpu_seq_ctrl #(.OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
    .load_ir(load_ir), .rd(rd), .wr(wr), .inc_pc(inc_pc), .load_pc(load_pc),
    .load_acc(load_acc), .datactl_ena(datactl_ena), .halt(halt),
    .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;
  assign vec = {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, instr_done};

  // Vector bits: load_ir rd wr inc_pc load_pc load_acc datactl_ena instr_done
  function automatic logic [7:0] model_vec(int s, logic [2:0] op, logic z);
    logic alu;
    alu = op inside {3'd2, 3'd3, 3'd4, 3'd5};
    case (s)
      0, 1:    return 8'hD0;
      3:       return alu ? 8'h40 : op == 3'd6 ? 8'h02 : 8'h00;
      4:       return alu ? 8'h44 : op == 3'd6 ? 8'h22 : op == 3'd7 ? 8'h08 : (op == 3'd1 && z) ? 8'h10 : 8'h00;
      5:       return op == 3'd6 ? 8'h02 : op == 3'd7 ? 8'h08 : (op == 3'd1 && z) ? 8'h10 : 8'h00;
      7:       return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_step <= 0;
      m_halt <= 1'b0;
    end else if (!m_halt) begin
      if (!ena) m_step <= 0;
      else if (m_step == 2 && opcode == 3'd0) m_halt <= 1'b1;
      else m_step <= (m_step + 1) % 8;
    end
  end

  always @(negedge clk) begin
    chk("model_vec", vec, (!rst_n || m_halt || !ena) ? 8'h00 : model_vec(m_step, opcode, zero));
    chk("model_state", 8'(state), (ena || m_halt) ? 8'(m_step) : 8'h00);
    chk("model_halt", 8'(halt), 8'(m_halt));
    chk("rd_wr_excl", 8'(rd & wr), 8'h00);
    chk("pc_excl", 8'(load_pc & inc_pc), 8'h00);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full instruction from S0; zero carries z only in S4/S5 and its inverse elsewhere.
  task automatic run_instr(string nm, logic [2:0] op, logic z, logic [63:0] e);
    opcode = op;
    for (int i = 0; i < 8; i++) begin
      zero = (i == 4 || i == 5) ? z : ~z;
      #1;
      chk({nm, "_state"}, 8'(state), 8'(i));
      chk({nm, "_vec"}, vec, e[63 - 8*i -: 8]);
      tick();
    end
    chk({nm, "_wrap"}, 8'(state), 8'h00);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_state", 8'(state), 8'h00);
    chk("rst_halt", 8'(halt), 8'h00);
    chk("rst_vec", vec, 8'h00);
    rst_n = 1'b1;
    run_instr("lda", 3'd5, 1'b0, 64'hD0D0_0040_4400_0001);
    run_instr("sto", 3'd6, 1'b0, 64'hD0D0_0002_2202_0001);
    run_instr("skz1", 3'd1, 1'b1, 64'hD0D0_0000_1010_0001);
    run_instr("skz0", 3'd1, 1'b0, 64'hD0D0_0000_0000_0001);
    run_instr("jmp", 3'd7, 1'b0, 64'hD0D0_0000_0808_0001);
    run_instr("add", 3'd2, 1'b0, 64'hD0D0_0040_4400_0001);
    opcode = 3'd2;
    repeat (4) tick();
    chk("abort_pre_state", 8'(state), 8'h04);
    ena = 1'b0;
    #1;
    chk("abort_s4_vec", vec, 8'h00);
    chk("abort_s4_state", 8'(state), 8'h00);
    tick();
    chk("abort_next_vec", vec, 8'h00);
    chk("abort_next_state", 8'(state), 8'h00);
    ena = 1'b1;
    #1;
    chk("refetch_vec", vec, 8'hD0);
    chk("refetch_state", 8'(state), 8'h00);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_state", 8'(state), 8'h00);
    chk("midrst_vec", vec, 8'h00);
    rst_n = 1'b1;
    opcode = 3'd0;
    tick();
    tick();
    chk("hlt_s2_state", 8'(state), 8'h02);
    chk("hlt_s2_halt", 8'(halt), 8'h00);
    tick();
    chk("hlt_set", 8'(halt), 8'h01);
    for (int i = 0; i < 20; i++) begin
      ena = i[0];
      #1;
      chk("hlt_hold_state", 8'(state), 8'h02);
      chk("hlt_hold_vec", vec, 8'h00);
      tick();
    end
    ena = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("hlt_rst_state", 8'(state), 8'h00);
    chk("hlt_rst_halt", 8'(halt), 8'h00);
    rst_n = 1'b1;
    opcode = 3'd5;
    #1;
    chk("post_rst_fetch", vec, 8'hD0);
    repeat (10) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
